// File: rtl/proc_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, single-ported memory
// between the TinyRV1 fetch port (0) and the load/store port (1).
module proc_mem_arbiter #(
  parameter int unsigned LAT = 2,
  parameter int unsigned CW  = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic        req0_wen,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [31:0] resp0_data,

  input  logic        req1_val,
  output logic        req1_rdy,
  input  logic        req1_wen,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [31:0] resp1_data,

  output logic        mem_val,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } state_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          owner_q, owner_d;
  logic          wen_q, wen_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;

  req_t req0, req1, win_req;
  logic any_val;
  logic winner;
  logic gnt;
  logic resp_hs;

  assign req0 = '{wen: req0_wen, addr: req0_addr, wdata: req0_wdata};
  assign req1 = '{wen: req1_wen, addr: req1_addr, wdata: req1_wdata};

  assign any_val = req0_val | req1_val;

  always_comb begin
    winner = prio_q;
    unique case (1'b1)
      req0_val && !req1_val: winner = 1'b0;
      req1_val && !req0_val: winner = 1'b1;
      default:               winner = prio_q;
    endcase
  end

  assign win_req = winner ? req1 : req0;

  // A grant made while rst is high would be thrown away, so none is offered.
  assign gnt = (state_q == IDLE) && !rst && any_val;

  assign resp_hs = (state_q == RESP) &&
                   (owner_q ? resp1_rdy : resp0_rdy);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    wen_d   = wen_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          owner_d = winner;
          prio_d  = ~winner;
          wen_d   = win_req.wen;
          cnt_d   = CNT_INIT;
          state_d = MEM;
        end
      end
      MEM: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rdata_d = wen_q ? 32'h0 : mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req0_rdy   = gnt && !winner;
    req1_rdy   = gnt &&  winner;
    mem_val    = gnt;
    mem_wen    = gnt && win_req.wen;
    mem_addr   = gnt ? win_req.addr  : 32'h0;
    mem_wdata  = gnt ? win_req.wdata : 32'h0;
    resp0_val  = (state_q == RESP) && !owner_q;
    resp1_val  = (state_q == RESP) &&  owner_q;
    resp0_data = resp0_val ? rdata_q : 32'h0;
    resp1_data = resp1_val ? rdata_q : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Directed bench for proc_mem_arbiter: a LAT=2 instance for the main
// sequence and a LAT=1 instance for the short-latency case.
module tb_proc_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // LAT=2 instance signals
  logic        rst;
  logic        r0v, r0w, r0rdy;
  logic [31:0] r0a, r0d;
  logic        p0v, p0r;
  logic [31:0] p0d;
  logic        r1v, r1w, r1rdy;
  logic [31:0] r1a, r1d;
  logic        p1v, p1r;
  logic [31:0] p1d;
  logic        mv, mw;
  logic [31:0] ma, md, mrd;

  // LAT=1 instance signals
  logic        rst_b;
  logic        q0v, q0w, q0rdy;
  logic [31:0] q0a, q0d;
  logic        b0v, b0r;
  logic [31:0] b0d;
  logic        q1v, q1w, q1rdy;
  logic [31:0] q1a, q1d;
  logic        b1v, b1r;
  logic [31:0] b1d;
  logic        bmv, bmw;
  logic [31:0] bma, bmd, bmrd;

  proc_mem_arbiter #(.LAT(2), .CW(4)) dut_a (
    .clk(clk), .rst(rst),
    .req0_val(r0v), .req0_rdy(r0rdy), .req0_wen(r0w),
    .req0_addr(r0a), .req0_wdata(r0d),
    .resp0_val(p0v), .resp0_rdy(p0r), .resp0_data(p0d),
    .req1_val(r1v), .req1_rdy(r1rdy), .req1_wen(r1w),
    .req1_addr(r1a), .req1_wdata(r1d),
    .resp1_val(p1v), .resp1_rdy(p1r), .resp1_data(p1d),
    .mem_val(mv), .mem_wen(mw), .mem_addr(ma),
    .mem_wdata(md), .mem_rdata(mrd)
  );

  proc_mem_arbiter #(.LAT(1), .CW(4)) dut_b (
    .clk(clk), .rst(rst_b),
    .req0_val(q0v), .req0_rdy(q0rdy), .req0_wen(q0w),
    .req0_addr(q0a), .req0_wdata(q0d),
    .resp0_val(b0v), .resp0_rdy(b0r), .resp0_data(b0d),
    .req1_val(q1v), .req1_rdy(q1rdy), .req1_wen(q1w),
    .req1_addr(q1a), .req1_wdata(q1d),
    .resp1_val(b1v), .resp1_rdy(b1r), .resp1_data(b1d),
    .mem_val(bmv), .mem_wen(bmw), .mem_addr(bma),
    .mem_wdata(bmd), .mem_rdata(bmrd)
  );

  // Memory models: read data appears exactly LAT cycles after mem_val.
  logic [31:0] mema [1024];
  logic [31:0] pa1, pa2;
  always @(posedge clk) begin
    if (rst) begin
      mema[10'h200] <= 32'h0000_0003;
      mema[10'h108] <= 32'h0000_0055;
    end else if (mv && mw) begin
      mema[ma[9:0]] <= md;
    end
    pa1 <= (mv && !mw) ? mema[ma[9:0]] : 32'ha5a5_a5a5;
    pa2 <= pa1;
  end
  assign mrd = pa2;

  logic [31:0] memb [1024];
  logic [31:0] pb1;
  always @(posedge clk) begin
    if (rst_b) begin
      memb[10'h000] <= 32'h0000_0042;
    end else if (bmv && bmw) begin
      memb[bma[9:0]] <= bmd;
    end
    pb1 <= (bmv && !bmw) ? memb[bma[9:0]] : 32'h5a5a_5a5a;
  end
  assign bmrd = pb1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    r0v = 0; r0w = 0; r0a = 0; r0d = 0; p0r = 0;
    r1v = 0; r1w = 0; r1a = 0; r1d = 0; p1r = 0;
    q0v = 0; q0w = 0; q0a = 0; q0d = 0; b0r = 1;
    q1v = 0; q1w = 0; q1a = 0; q1d = 0; b1r = 1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req0_rdy", r0rdy, 1'b0);
    chk1("rst_req1_rdy", r1rdy, 1'b0);
    chk1("rst_resp0_val", p0v, 1'b0);
    chk1("rst_resp1_val", p1v, 1'b0);
    chk1("rst_mem_val", mv, 1'b0);
    chk32("rst_mem_addr", ma, 32'h0);
    chk32("rst_resp0_data", p0d, 32'h0);

    @(negedge clk);
    rst = 1'b0; rst_b = 1'b0; p0r = 1; p1r = 1;

    // 1: single port-0 load of 0x200
    @(negedge clk);
    r0v = 1; r0w = 0; r0a = 32'h200;
    #1;
    chk1("t1_gnt_rdy0", r0rdy, 1'b1);
    chk1("t1_gnt_rdy1", r1rdy, 1'b0);
    chk1("t1_gnt_memval", mv, 1'b1);
    chk1("t1_gnt_memwen", mw, 1'b0);
    chk32("t1_gnt_memaddr", ma, 32'h200);
    @(negedge clk);
    r0v = 0;
    #1;
    chk1("t1_g1_memval", mv, 1'b0);
    chk1("t1_g1_rdy0", r0rdy, 1'b0);
    chk1("t1_g1_resp0", p0v, 1'b0);
    @(negedge clk);
    #1;
    chk1("t1_g2_resp0", p0v, 1'b0);
    @(negedge clk);
    #1;
    chk1("t1_g3_resp0_val", p0v, 1'b1);
    chk32("t1_g3_resp0_data", p0d, 32'h3);
    chk1("t1_g3_resp1_val", p1v, 1'b0);
    chk32("t1_g3_resp1_data", p1d, 32'h0);
    @(negedge clk);
    #1;
    chk1("t1_g4_resp0", p0v, 1'b0);

    // 2: both ports always valid after reset -> 0,1,0,1
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r0v = 1; r0w = 0; r0a = 32'h200;
    r1v = 1; r1w = 0; r1a = 32'h108;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk1($sformatf("t2_rdy0_k%0d", k), r0rdy, (k % 2) == 0);
      chk1($sformatf("t2_rdy1_k%0d", k), r1rdy, (k % 2) == 1);
      chk32($sformatf("t2_addr_k%0d", k), ma,
            ((k % 2) == 1) ? 32'h108 : 32'h200);
      repeat (3) @(negedge clk);
      #1;
      chk1($sformatf("t2_rv0_k%0d", k), p0v, (k % 2) == 0);
      chk1($sformatf("t2_rv1_k%0d", k), p1v, (k % 2) == 1);
      chk32($sformatf("t2_rd_k%0d", k), ((k % 2) == 1) ? p1d : p0d,
            ((k % 2) == 1) ? 32'h55 : 32'h3);
    end

    // 3: port-1 store then load of 0x104
    @(negedge clk);
    r0v = 0;
    r1v = 1; r1w = 1; r1a = 32'h104; r1d = 32'hdead_beef;
    #1;
    chk1("t3_st_rdy1", r1rdy, 1'b1);
    chk1("t3_st_memwen", mw, 1'b1);
    chk32("t3_st_wdata", md, 32'hdead_beef);
    @(negedge clk);
    r1v = 0;
    repeat (2) @(negedge clk);
    #1;
    chk1("t3_st_resp1_val", p1v, 1'b1);
    chk32("t3_st_resp1_data", p1d, 32'h0);
    @(negedge clk);
    r1v = 1; r1w = 0; r1d = 32'h0;
    #1;
    chk1("t3_ld_rdy1", r1rdy, 1'b1);
    chk1("t3_ld_memwen", mw, 1'b0);
    @(negedge clk);
    r1v = 0;
    repeat (2) @(negedge clk);
    #1;
    chk1("t3_ld_resp1_val", p1v, 1'b1);
    chk32("t3_ld_resp1_data", p1d, 32'hdead_beef);

    // 4: resp0 backpressure, resp1_rdy high but ignored
    @(negedge clk);
    p0r = 0;
    r0v = 1; r0w = 0; r0a = 32'h200;
    #1;
    chk1("t4_gnt_rdy0", r0rdy, 1'b1);
    @(negedge clk);
    r0v = 0;
    repeat (2) @(negedge clk);
    r0v = 1; r1v = 1; r1a = 32'h108;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk1($sformatf("t4_hold_val_%0d", i), p0v, 1'b1);
      chk32($sformatf("t4_hold_data_%0d", i), p0d, 32'h3);
      chk1($sformatf("t4_hold_rdy0_%0d", i), r0rdy, 1'b0);
      chk1($sformatf("t4_hold_rdy1_%0d", i), r1rdy, 1'b0);
      chk1($sformatf("t4_hold_mv_%0d", i), mv, 1'b0);
    end
    @(negedge clk);
    p0r = 1;
    #1;
    chk1("t4_hs_val", p0v, 1'b1);
    chk1("t4_hs_mv", mv, 1'b0);
    @(negedge clk);
    #1;
    chk1("t4_next_rdy1", r1rdy, 1'b1);
    chk1("t4_next_rdy0", r0rdy, 1'b0);
    chk1("t4_next_mv", mv, 1'b1);
    chk32("t4_next_addr", ma, 32'h108);
    @(negedge clk);
    r0v = 0; r1v = 0;
    repeat (2) @(negedge clk);
    #1;
    chk1("t4_resp1_val", p1v, 1'b1);
    chk32("t4_resp1_data", p1d, 32'h55);

    // 5: reset during MEM of a port-1 load
    @(negedge clk);
    r1v = 1; r1w = 0; r1a = 32'h108;
    #1;
    chk1("t5_gnt_rdy1", r1rdy, 1'b1);
    @(negedge clk);
    r1v = 0; rst = 1'b1;
    @(negedge clk);
    #1;
    chk1("t5_rst_resp1", p1v, 1'b0);
    chk1("t5_rst_resp0", p0v, 1'b0);
    chk1("t5_rst_mv", mv, 1'b0);
    chk32("t5_rst_resp1_data", p1d, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    r0v = 1; r0a = 32'h200;
    r1v = 1; r1a = 32'h108;
    #1;
    chk1("t5_rel_rdy0", r0rdy, 1'b1);
    chk1("t5_rel_rdy1", r1rdy, 1'b0);
    @(negedge clk);
    r0v = 0;
    #1;
    chk1("t5_g1_resp1", p1v, 1'b0);
    @(negedge clk);
    #1;
    chk1("t5_g2_resp1", p1v, 1'b0);
    @(negedge clk);
    #1;
    chk1("t5_g3_resp0", p0v, 1'b1);
    chk32("t5_g3_data0", p0d, 32'h3);
    chk1("t5_g3_resp1", p1v, 1'b0);
    @(negedge clk);
    #1;
    chk1("t5_g4_rdy1", r1rdy, 1'b1);
    chk32("t5_g4_addr", ma, 32'h108);
    @(negedge clk);
    r1v = 0;
    repeat (2) @(negedge clk);
    #1;
    chk1("t5_resp1_val", p1v, 1'b1);
    chk32("t5_resp1_data", p1d, 32'h55);

    // 6: LAT=1 instance, back-to-back loads of 0x0
    @(negedge clk);
    q0v = 1; q0w = 0; q0a = 32'h0;
    #1;
    chk1("t6_gnt_rdy0", q0rdy, 1'b1);
    chk1("t6_gnt_mv", bmv, 1'b1);
    @(negedge clk);
    #1;
    chk1("t6_g1_rdy0", q0rdy, 1'b0);
    chk1("t6_g1_mv", bmv, 1'b0);
    chk1("t6_g1_resp0", b0v, 1'b0);
    @(negedge clk);
    #1;
    chk1("t6_g2_resp0", b0v, 1'b1);
    chk32("t6_g2_data0", b0d, 32'h42);
    @(negedge clk);
    #1;
    chk1("t6_g3_rdy0", q0rdy, 1'b1);
    chk1("t6_g3_mv", bmv, 1'b1);
    @(negedge clk);
    q0v = 0;
    @(negedge clk);
    #1;
    chk1("t6_g5_resp0", b0v, 1'b1);
    chk32("t6_g5_data0", b0d, 32'h42);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
